// File: rtl/mbist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mbist_pkg
// Brief    : Shared types and helpers for the repairable memory and its CAM.
// Revision : 1.0 - initial release
// ============================================================================
package mbist_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_CLEAR = 1'b0;
    localparam state_t ST_READY = 1'b1;

    // Spare-row index width; a single spare still needs a one-bit index.
    function automatic int spare_idx_w(input int spare_rows);
        return (spare_rows > 1) ? $clog2(spare_rows) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/repair_cam.sv
`default_nettype none
// ============================================================================
// Module   : repair_cam
// Brief    : Repair remap table: lookup with lowest-index hit, duplicate check,
//            fill count, full flag and sticky overflow.
// Revision : 1.0 - initial release
// ============================================================================
module repair_cam
    import mbist_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_SIZE   = 256,
    parameter int SPARE_ROWS = 4,
    localparam int SIDX_W    = spare_idx_w(SPARE_ROWS),
    localparam int CNT_W     = $clog2(SPARE_ROWS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
    output logic                  hit_o,
    output logic [SIDX_W-1:0]     hit_idx_o,
    input  logic                  repair_en_i,
    input  logic [ADDR_WIDTH-1:0] repair_addr_i,
    output logic [CNT_W-1:0]      count_o,
    output logic                  full_o,
    output logic                  ovf_o
);

    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);

    logic [SPARE_ROWS-1:0] valid_q;
    logic [ADDR_WIDTH-1:0] addr_q [SPARE_ROWS];
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [SPARE_ROWS-1:0] lk_match;
    logic [SPARE_ROWS-1:0] rp_match;
    logic [SIDX_W-1:0]     free_idx;
    logic                  rp_in_range;
    logic                  rp_dup;
    logic                  rp_accept;

    generate
        for (genvar i = 0; i < SPARE_ROWS; i++) begin : g_match
            assign lk_match[i] = valid_q[i] && (addr_q[i] == lookup_addr_i);
            assign rp_match[i] = valid_q[i] && (addr_q[i] == repair_addr_i);
        end
    endgenerate

    // Descending scans leave the lowest matching / free index as the winner.
    always_comb begin
        hit_o     = 1'b0;
        hit_idx_o = '0;
        free_idx  = '0;
        for (int i = SPARE_ROWS - 1; i >= 0; i--) begin
            if (lk_match[i]) begin
                hit_o     = 1'b1;
                hit_idx_o = SIDX_W'(i);
            end
            if (!valid_q[i]) begin
                free_idx = SIDX_W'(i);
            end
        end
    end

    assign rp_in_range = {1'b0, repair_addr_i} < MEM_LIMIT;
    assign rp_dup      = |rp_match;
    assign full_o      = (count_q == CNT_W'(SPARE_ROWS));
    assign count_o     = count_q;
    assign ovf_o       = ovf_q;

    always_comb begin
        rp_accept = repair_en_i && rp_in_range && !rp_dup && !full_o;
        count_d   = count_q;
        ovf_d     = ovf_q;
        if (rp_accept) begin
            count_d = count_q + CNT_W'(1);
        end
        if (repair_en_i && rp_in_range && !rp_dup && full_o) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < SPARE_ROWS; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (rp_accept) begin
                valid_q[free_idx] <= 1'b1;
                addr_q[free_idx]  <= repair_addr_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/repairable_memory.sv
`default_nettype none
// ============================================================================
// Module   : repairable_memory
// Brief    : Single-port memory with spare-row remap, registered read and a
//            sequential clear sweep. Optional macro: FAULT_INJECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module repairable_memory
    import mbist_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_SIZE   = 256,
    parameter int SPARE_ROWS = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
`ifdef FAULT_INJECT_EN
    input  logic                               fi_en,
    input  logic [ADDR_WIDTH-1:0]              fi_addr,
    input  logic [$clog2(DATA_WIDTH)-1:0]      fi_bit,
    input  logic                               fi_val,
`endif
    input  logic                               mem_en,
    input  logic                               mem_we,
    input  logic [ADDR_WIDTH-1:0]              mem_addr,
    input  logic [DATA_WIDTH-1:0]              mem_wdata,
    output logic [DATA_WIDTH-1:0]              mem_rdata,
    output logic                               mem_rvalid,
    output logic                               mem_ready,
    output logic                               oob_err,
    input  logic                               init_start,
    input  logic                               repair_en,
    input  logic [ADDR_WIDTH-1:0]              repair_addr,
    output logic [$clog2(SPARE_ROWS+1)-1:0]    repair_count,
    output logic                               repair_full,
    output logic                               repair_ovf
);

    localparam int ROWS   = MEM_SIZE + SPARE_ROWS;
    localparam int PHYS_W = $clog2(ROWS);
    localparam int SIDX_W = spare_idx_w(SPARE_ROWS);
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);
    localparam logic [PHYS_W-1:0]   LAST_ROW  = PHYS_W'(ROWS - 1);

    state_t                state_q, state_d;
    logic [PHYS_W-1:0]     ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [ROWS];
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  oob_q, oob_d;

    logic                  clear_we;
    logic                  hit;
    logic [SIDX_W-1:0]     hit_idx;
    logic                  in_range;
    logic                  acc;
    logic                  wr_en;
    logic [PHYS_W-1:0]     phys;
    logic [DATA_WIDTH-1:0] rd_word;

    repair_cam #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_SIZE   (MEM_SIZE),
        .SPARE_ROWS (SPARE_ROWS)
    ) u_cam (
        .clk           (clk),
        .rst_n         (rst_n),
        .lookup_addr_i (mem_addr),
        .hit_o         (hit),
        .hit_idx_o     (hit_idx),
        .repair_en_i   (repair_en),
        .repair_addr_i (repair_addr),
        .count_o       (repair_count),
        .full_o        (repair_full),
        .ovf_o         (repair_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                if (init_start) begin
                    ptr_d = '0;
                end else if (ptr_q == LAST_ROW) begin
                    state_d = ST_READY;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + PHYS_W'(1);
                end
            end
            ST_READY: begin
                if (init_start) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_comb begin
        mem_ready = (state_q == ST_READY);
        clear_we  = (state_q == ST_CLEAR);
    end

    // Remapped addresses land on the spares stacked above the main array.
    assign in_range = {1'b0, mem_addr} < MEM_LIMIT;
    assign acc      = mem_ready && mem_en;
    assign wr_en    = acc && mem_we && in_range;
    assign phys     = hit ? PHYS_W'(MEM_SIZE + int'(hit_idx)) : PHYS_W'(mem_addr);

    always_comb begin
        rd_word = mem_q[phys];
`ifdef FAULT_INJECT_EN
        if (fi_en && !hit && (mem_addr == fi_addr)) begin
            rd_word[fi_bit] = fi_val;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem_q[ptr_q] <= '0;
        end else if (wr_en) begin
            mem_q[phys] <= mem_wdata;
        end
    end

    always_comb begin
        rvalid_d = acc && !mem_we;
        oob_d    = acc && !in_range;
        rdata_d  = rdata_q;
        if (rvalid_d) begin
            rdata_d = in_range ? rd_word : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            oob_q    <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            oob_q    <= oob_d;
        end
    end

    assign mem_rdata  = rdata_q;
    assign mem_rvalid = rvalid_q;
    assign oob_err    = oob_q;

endmodule
`default_nettype wire

// File: tb/tb_repairable_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_repairable_memory
// Brief    : Self-checking bench for repairable_memory against a behavioural
//            model. Optional macro: FAULT_INJECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_repairable_memory;

    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int MS   = 200;
    localparam int SR   = 4;
    localparam int ROWS = MS + SR;
    localparam int CW   = $clog2(SR + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_en = 1'b0;
    logic          mem_we = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic [DW-1:0] mem_rdata;
    logic          mem_rvalid;
    logic          mem_ready;
    logic          oob_err;
    logic          init_start = 1'b0;
    logic          repair_en = 1'b0;
    logic [AW-1:0] repair_addr = '0;
    logic [CW-1:0] repair_count;
    logic          repair_full;
    logic          repair_ovf;
`ifdef FAULT_INJECT_EN
    logic                  fi_en = 1'b0;
    logic [AW-1:0]         fi_addr = '0;
    logic [$clog2(DW)-1:0] fi_bit = '0;
    logic                  fi_val = 1'b0;
`endif

    repairable_memory #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_SIZE   (MS),
        .SPARE_ROWS (SR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef FAULT_INJECT_EN
        .fi_en        (fi_en),
        .fi_addr      (fi_addr),
        .fi_bit       (fi_bit),
        .fi_val       (fi_val),
`endif
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid),
        .mem_ready    (mem_ready),
        .oob_err      (oob_err),
        .init_start   (init_start),
        .repair_en    (repair_en),
        .repair_addr  (repair_addr),
        .repair_count (repair_count),
        .repair_full  (repair_full),
        .repair_ovf   (repair_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: logical main storage, spares, ordered list of retired addresses.
    logic [DW-1:0] main_m  [MS];
    logic [DW-1:0] spare_m [SR];
    int            rep_q[$];
    bit            ovf_m;

    function automatic int find_rep(input int a);
        foreach (rep_q[i]) if (rep_q[i] == a) return i;
        return -1;
    endfunction

    function automatic logic [DW-1:0] model_read(input int a);
        int idx = find_rep(a);
        return (idx >= 0) ? spare_m[idx] : main_m[a];
    endfunction

    function automatic void model_write(input int a, input logic [DW-1:0] d);
        int idx = find_rep(a);
        if (idx >= 0) spare_m[idx] = d;
        else          main_m[a]    = d;
    endfunction

    function automatic void model_repair(input int a);
        if (a >= MS || find_rep(a) >= 0) return;
        if (rep_q.size() == SR) ovf_m = 1'b1;
        else                    rep_q.push_back(a);
    endfunction

    function automatic void model_reset();
        rep_q.delete();
        ovf_m = 1'b0;
    endfunction

    function automatic void model_clear();
        foreach (main_m[i])  main_m[i]  = '0;
        foreach (spare_m[i]) spare_m[i] = '0;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        mem_en = 1'b0; mem_we = 1'b0; init_start = 1'b0; repair_en = 1'b0;
    endtask

    // Hammers the port during the sweep; any rvalid/oob seen is reported back.
    task automatic wait_ready(output int n, output bit spur);
        n = 0; spur = 1'b0;
        while (!mem_ready && n < 2000) begin
            mem_en = 1'b1; mem_we = n[0];
            mem_addr = n[0] ? 8'h30 : 8'hF0; mem_wdata = 8'hFF;
            cyc(); n++;
            if (mem_rvalid || oob_err) spur = 1'b1;
        end
        mem_en = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic v, output logic o);
        mem_en = 1'b1; mem_we = 1'b0; mem_addr = a;
        cyc();
        d = mem_rdata; v = mem_rvalid; o = oob_err;
        mem_en = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, output logic v, output logic o);
        mem_en = 1'b1; mem_we = 1'b1; mem_addr = a; mem_wdata = d;
        cyc();
        v = mem_rvalid; o = oob_err;
        mem_en = 1'b0; mem_we = 1'b0;
    endtask

    task automatic repair(input logic [AW-1:0] a);
        repair_en = 1'b1; repair_addr = a;
        cyc();
        repair_en = 1'b0;
        model_repair(int'(a));
    endtask

    task automatic test_reset();
        logic [DW-1:0] d; logic v, o; int n; bit spur;
        rst_n = 1'b0; set_idle();
        repeat (3) cyc();
        n_checks++; if ({mem_ready, mem_rvalid, oob_err, repair_full, repair_ovf, repair_count, mem_rdata} !== '0)
            $display("FAIL reset_outputs: got rdy=%b rv=%b oob=%b full=%b ovf=%b cnt=%0d rd=%h exp all 0",
                     mem_ready, mem_rvalid, oob_err, repair_full, repair_ovf, repair_count, mem_rdata);
        else n_pass++;
        rst_n = 1'b1; model_reset();
        wait_ready(n, spur); model_clear();
        n_checks++; if (n !== ROWS) $display("FAIL reset_clear_len: got %0d exp %0d", n, ROWS); else n_pass++;
        n_checks++; if (spur !== 1'b0) $display("FAIL clear_ignores_access: got %b exp 0", spur); else n_pass++;
        rd(8'h10, d, v, o);
        n_checks++; if ({v, o, d} !== {1'b1, 1'b0, 8'h00}) $display("FAIL reset_read: got v=%b o=%b d=%h exp 1 0 00", v, o, d); else n_pass++;
        cyc();
        n_checks++; if (mem_rvalid !== 1'b0) $display("FAIL rvalid_pulse: got %b exp 0", mem_rvalid); else n_pass++;
    endtask

    task automatic test_basic();
        logic [DW-1:0] d; logic v, o;
        wr(8'h20, 8'hA5, v, o); model_write(8'h20, 8'hA5);
        n_checks++; if ({v, o} !== 2'b00) $display("FAIL write_flags: got v=%b o=%b exp 0 0", v, o); else n_pass++;
        rd(8'h20, d, v, o);
        n_checks++; if ({v, o, d} !== {1'b1, 1'b0, 8'hA5}) $display("FAIL basic_read: got v=%b o=%b d=%h exp 1 0 a5", v, o, d); else n_pass++;
        cyc();
        n_checks++; if ({mem_rvalid, mem_rdata} !== {1'b0, 8'hA5}) $display("FAIL rdata_hold: got v=%b d=%h exp 0 a5", mem_rvalid, mem_rdata); else n_pass++;
    endtask

    task automatic test_oob();
        logic [DW-1:0] d; logic v, o;
        wr(8'hF0, 8'h77, v, o);
        n_checks++; if ({v, o} !== 2'b01) $display("FAIL oob_write: got v=%b o=%b exp 0 1", v, o); else n_pass++;
        cyc();
        n_checks++; if (oob_err !== 1'b0) $display("FAIL oob_pulse: got %b exp 0", oob_err); else n_pass++;
        rd(8'hF0, d, v, o);
        n_checks++; if ({v, o, d} !== {1'b1, 1'b1, 8'h00}) $display("FAIL oob_read: got v=%b o=%b d=%h exp 1 1 00", v, o, d); else n_pass++;
        wr(8'(MS - 1), 8'h5A, v, o); model_write(MS - 1, 8'h5A);
        rd(8'(MS - 1), d, v, o);
        n_checks++; if ({o, d} !== {1'b0, 8'h5A}) $display("FAIL last_row: got o=%b d=%h exp 0 5a", o, d); else n_pass++;
        rd(8'(MS), d, v, o);
        n_checks++; if ({o, d} !== {1'b1, 8'h00}) $display("FAIL first_oob: got o=%b d=%h exp 1 00", o, d); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a; logic [DW-1:0] wd;
        for (int k = 0; k < 8; k++) begin
            a = AW'($urandom_range(0, MS - 1)); wd = DW'($urandom);
            mem_en = 1'b1; mem_we = 1'b1; mem_addr = a; mem_wdata = wd;
            cyc(); model_write(a, wd);
            mem_we = 1'b0;
            cyc();
            n_checks++; if (mem_rdata !== model_read(a)) $display("FAIL b2b_read a=%h: got %h exp %h", a, mem_rdata, model_read(a)); else n_pass++;
        end
        mem_en = 1'b0;
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_d, wd; logic [AW-1:0] a, ra;
        bit known, en, we, ren, exp_v, exp_o;
        known = 1'b0; exp_d = '0;
        for (int k = 0; k < 400; k++) begin
            en = ($urandom_range(0, 3) != 0); we = 1'($urandom_range(0, 1));
            if (rep_q.size() > 0 && $urandom_range(0, 3) == 0)
                a = AW'(rep_q[$urandom_range(0, rep_q.size() - 1)]);
            else
                a = AW'($urandom_range(0, 255));
            wd = DW'($urandom); ren = ($urandom_range(0, 15) == 0);
            ra = ($urandom_range(0, 1) != 0) ? a : AW'($urandom_range(0, 255));
            exp_v = en && !we; exp_o = en && (int'(a) >= MS);
            if (exp_v) begin exp_d = exp_o ? '0 : model_read(a); known = 1'b1; end
            if (en && we && !exp_o) model_write(a, wd);
            mem_en = en; mem_we = we; mem_addr = a; mem_wdata = wd;
            repair_en = ren; repair_addr = ra;
            cyc();
            if (ren) model_repair(ra);
            n_checks++; if (mem_rvalid !== exp_v) $display("FAIL rand_rvalid k=%0d: got %b exp %b", k, mem_rvalid, exp_v); else n_pass++;
            n_checks++; if (oob_err !== exp_o) $display("FAIL rand_oob k=%0d: got %b exp %b", k, oob_err, exp_o); else n_pass++;
            if (known) begin
                n_checks++; if (mem_rdata !== exp_d) $display("FAIL rand_rdata k=%0d a=%h: got %h exp %h", k, a, mem_rdata, exp_d); else n_pass++;
            end
            n_checks++; if ({repair_count, repair_full, repair_ovf} !== {CW'(rep_q.size()), rep_q.size() == SR, ovf_m})
                $display("FAIL rand_table k=%0d: got cnt=%0d full=%b ovf=%b exp cnt=%0d ovf=%b",
                         k, repair_count, repair_full, repair_ovf, rep_q.size(), ovf_m);
            else n_pass++;
        end
        set_idle();
    endtask

    task automatic test_midclear_reset();
        int n; bit spur; bit early;
        mem_en = 1'b1; mem_we = 1'b0; mem_addr = 8'h11;
        cyc(); mem_en = 1'b0;
        n_checks++; if (mem_rvalid !== 1'b1) $display("FAIL inflight_rvalid: got %b exp 1", mem_rvalid); else n_pass++;
        rst_n = 1'b0; #1;
        n_checks++; if ({mem_rvalid, repair_ovf, repair_count, mem_ready} !== '0)
            $display("FAIL async_reset: got rv=%b ovf=%b cnt=%0d rdy=%b exp 0", mem_rvalid, repair_ovf, repair_count, mem_ready);
        else n_pass++;
        cyc(); rst_n = 1'b1; model_reset();
        early = 1'b0;
        for (int k = 0; k < 100; k++) begin cyc(); if (mem_ready) early = 1'b1; end
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        wait_ready(n, spur); model_clear();
        n_checks++; if (early !== 1'b0) $display("FAIL midclear_ready: got %b exp 0", early); else n_pass++;
        n_checks++; if (n !== ROWS) $display("FAIL midclear_len: got %0d exp %0d", n, ROWS); else n_pass++;
    endtask

    task automatic test_repair();
        logic [DW-1:0] d; logic v, o;
        wr(8'h20, 8'hA5, v, o); model_write(8'h20, 8'hA5);
        repair(8'h20);
        n_checks++; if (repair_count !== CW'(1)) $display("FAIL rep_count1: got %0d exp 1", repair_count); else n_pass++;
        rd(8'h20, d, v, o);
        n_checks++; if (d !== 8'h00) $display("FAIL rep_spare_zero: got %h exp 00", d); else n_pass++;
        wr(8'h20, 8'h3C, v, o); model_write(8'h20, 8'h3C);
        rd(8'h20, d, v, o);
        n_checks++; if (d !== 8'h3C) $display("FAIL rep_spare_rw: got %h exp 3c", d); else n_pass++;
        repair(8'hF0);
        n_checks++; if (repair_count !== CW'(1)) $display("FAIL rep_oob_ignored: got %0d exp 1", repair_count); else n_pass++;
        repair(8'h31); repair(8'h42);
        n_checks++; if ({repair_count, repair_full} !== {CW'(3), 1'b0}) $display("FAIL rep_count3: got %0d full=%b exp 3 0", repair_count, repair_full); else n_pass++;
        repair(8'h53);
        n_checks++; if ({repair_count, repair_full, repair_ovf} !== {CW'(4), 1'b1, 1'b0})
            $display("FAIL rep_full: got %0d full=%b ovf=%b exp 4 1 0", repair_count, repair_full, repair_ovf);
        else n_pass++;
        repair(8'h64);
        n_checks++; if ({repair_count, repair_ovf} !== {CW'(4), 1'b1}) $display("FAIL rep_ovf: got %0d ovf=%b exp 4 1", repair_count, repair_ovf); else n_pass++;
        repair(8'h20);
        n_checks++; if (repair_count !== CW'(4)) $display("FAIL rep_dup: got %0d exp 4", repair_count); else n_pass++;
        wr(8'h53, 8'h99, v, o); model_write(8'h53, 8'h99);
        rd(8'h20, d, v, o);
        n_checks++; if (d !== model_read(8'h20)) $display("FAIL rep_distinct: got %h exp %h", d, model_read(8'h20)); else n_pass++;
        rd(8'h53, d, v, o);
        n_checks++; if (d !== model_read(8'h53)) $display("FAIL rep_spare3: got %h exp %h", d, model_read(8'h53)); else n_pass++;
    endtask

    task automatic test_init();
        logic [DW-1:0] d; logic v, o; int n; bit spur;
        wr(8'h10, 8'h55, v, o);
        init_start = 1'b1; cyc(); init_start = 1'b0;
        wait_ready(n, spur); model_clear();
        n_checks++; if (n + 1 !== ROWS + 1) $display("FAIL init_len: got %0d exp %0d", n + 1, ROWS + 1); else n_pass++;
        n_checks++; if (repair_count !== CW'(rep_q.size())) $display("FAIL init_keeps_table: got %0d exp %0d", repair_count, rep_q.size()); else n_pass++;
        rd(8'h10, d, v, o);
        n_checks++; if (d !== 8'h00) $display("FAIL init_main_clr: got %h exp 00", d); else n_pass++;
        rd(8'h20, d, v, o);
        n_checks++; if (d !== 8'h00) $display("FAIL init_spare_clr: got %h exp 00", d); else n_pass++;
        init_start = 1'b1; cyc(); init_start = 1'b0;
        repeat (50) cyc();
        init_start = 1'b1; cyc(); init_start = 1'b0;
        wait_ready(n, spur);
        n_checks++; if (n + 1 !== ROWS + 1) $display("FAIL init_restart_len: got %0d exp %0d", n + 1, ROWS + 1); else n_pass++;
    endtask

`ifdef FAULT_INJECT_EN
    task automatic test_fault_inject();
        logic [DW-1:0] d; logic v, o; int n; bit spur;
        rst_n = 1'b0; cyc(); rst_n = 1'b1; model_reset();
        wait_ready(n, spur); model_clear();
        fi_en = 1'b1; fi_addr = 8'h05; fi_bit = '0; fi_val = 1'b1;
        wr(8'h05, 8'h00, v, o);
        rd(8'h05, d, v, o);
        n_checks++; if (d !== 8'h01) $display("FAIL fi_forced: got %h exp 01", d); else n_pass++;
        repair(8'h05);
        wr(8'h05, 8'h00, v, o);
        rd(8'h05, d, v, o);
        n_checks++; if (d !== 8'h00) $display("FAIL fi_repaired: got %h exp 00", d); else n_pass++;
        fi_en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_oob();
        test_back_to_back();
        test_random();
        test_midclear_reset();
        test_repair();
        test_init();
`ifdef FAULT_INJECT_EN
        test_fault_inject();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/repairable_memory.md
# repairable_memory

Parametrised synchronous single-port memory with spare-row redundancy, for the MBIST/MBISR datapath. Adds a registered read with valid strobe and a sequential clear engine that replaces per-cycle array reset. It also has a repair remap table that steers faulty main-array addresses to spare rows. The MBIST controller is the test-time master and the functional logic is the mission-time master; both reach it through the same port.

## Interface
- ADDR_WIDTH, 8, logical address width
- DATA_WIDTH, 8, word width
- MEM_SIZE, 256, main-array rows (≤ 2^ADDR_WIDTH)
- SPARE_ROWS, 4, spare rows and repair-table entries (1..16)
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_en  in  1  access request
- mem_we  in  1  1 = write, 0 = read
- mem_addr  in  ADDR_WIDTH  logical address
- mem_wdata  in  DATA_WIDTH  write data
- mem_rdata  out  DATA_WIDTH  registered read data
- mem_rvalid  out  1  one-cycle pulse, mem_rdata valid
- mem_ready  out  1  array accepts accesses
- oob_err  out  1  one-cycle pulse, accepted access had mem_addr ≥ MEM_SIZE
- init_start  in  1  pulse: clear all main and spare rows
- repair_en  in  1  pulse: add repair_addr to remap table
- repair_addr  in  ADDR_WIDTH  address to retire
- repair_count  out  $clog2(SPARE_ROWS+1)  entries in use
- repair_full  out  1  repair_count == SPARE_ROWS
- repair_ovf  out  1  sticky: repair request dropped because table was full

## Operation
- FSM states: CLEAR, READY. Encoding: CLEAR=0, READY=1.
- Reset asserted: state=CLEAR, sweep pointer=0, table emptied, all outputs 0. Array contents are not reset.
- CLEAR: writes 0 to one physical row per cycle, main rows 0..MEM_SIZE-1 then spares 0..SPARE_ROWS-1. After the last row the FSM goes to READY. mem_ready=0 throughout; mem_en is ignored, with no rvalid and no oob_err.
- READY: mem_ready=1. init_start moves the FSM to CLEAR with pointer 0. The remap table is kept.
- init_start while in CLEAR restarts the sweep at 0.
- Remap: a lookup compares mem_addr with all valid entries. The lowest-index hit selects spare row i. A miss selects main row mem_addr.
- Write (mem_en & mem_we, in range): the selected physical row is updated at the edge.
- Write out of range: array is unchanged; oob_err pulses.
- Read (mem_en & !mem_we): mem_rdata is loaded from the selected row at the edge and mem_rvalid=1 next cycle. An out-of-range read loads 0 and pulses oob_err together with rvalid.
- mem_rdata holds its last value when mem_rvalid=0.
- Repair (repair_en, any state):
  - repair_addr already in the table: no change.
  - repair_addr ≥ MEM_SIZE: ignored.
  - Table full: entry dropped, repair_ovf set.
  - Otherwise: written to the lowest free entry; repair_count+1.
- Spare rows hold 0 after CLEAR. Data is not migrated on repair.

## Timing
- Read latency 1 cycle: request at edge N, rdata/rvalid valid after edge N+1.
- Write visible to a read issued the next cycle.
- Clear takes MEM_SIZE+SPARE_ROWS cycles. mem_ready rises the cycle after the last spare row is written.
- A repair issued in the same cycle as an access to the same address: the access uses the old mapping. The new mapping takes effect the following cycle.
- rst_n deassertion mid-operation: any in-flight rvalid is lost and CLEAR restarts from 0.
- repair_ovf clears only on reset.

## Configuration
- FAULT_INJECT_EN defined: adds these inputs:
  - fi_en  1
  - fi_addr  ADDR_WIDTH
  - fi_bit  $clog2(DATA_WIDTH)
  - fi_val  1
- With fi_en=1, a read whose selected physical row is main row fi_addr returns bit fi_bit forced to fi_val (stuck-at). Stored data is untouched.
- A repaired fi_addr is therefore fault-free: the read goes to a spare row.
- FAULT_INJECT_EN undefined: the fi_* ports and forcing logic are absent. Reads return stored data exactly.

## Structure
- Shared package mbist_pkg holds:
  - FSM state encoding (CLEAR/READY)
  - spare-index width constant derived from SPARE_ROWS
- One sub-module, repair_cam, contains:
  - the valid/address table
  - the lowest-index hit encoder
  - the duplicate check
  - count, full and ovf logic
- Top level holds the FSM, sweep pointer, physical array (MEM_SIZE+SPARE_ROWS rows) and read register.

## Test plan
- Reset release, DATA_WIDTH=8, MEM_SIZE=256 → mem_ready=0 for 260 cycles then 1; read of addr 0x10 returns 0x00 with rvalid 1 cycle later.
- Write 0xA5 @0x20, read 0x20 next cycle → rdata=0xA5, rvalid pulse, oob_err=0.
- repair_en 0x20, then read 0x20 → 0x00 (spare). Write 0x3C @0x20, read → 0x3C. repair_count=1.
- Five distinct repairs with SPARE_ROWS=4 → repair_full=1 after the 4th; 5th dropped; repair_ovf=1; repeat of 0x20 leaves count at 4.
- MEM_SIZE=200: write @0xF0 → oob_err pulse, no array change; read @0xF0 → rdata=0, rvalid+oob_err.
- FAULT_INJECT_EN: fi_addr=0x05, fi_bit=0, fi_val=1, write 0x00 @0x05 → read 0x01. After repair_en 0x05, write 0x00 → read 0x00. Mid-CLEAR rst_n pulse → sweep restarts, mem_ready stays 0 a full 260 cycles.
